// File: rtl/img_mem_arbiter_pkg.sv
// Shared definitions for the image-memory arbiter: FSM states, requester IDs
// and default widths.
package img_mem_arbiter_pkg;

  localparam int DEF_ADDR_WIDTH = 19;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_TIMEOUT    = 255;
  localparam int TO_CNT_WIDTH   = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ID_UART   = 2'd0,
    ID_CPU_WR = 2'd1,
    ID_CPU_RD = 2'd2
  } req_id_t;

  function automatic req_id_t onehot_to_id(input logic [2:0] oh);
    req_id_t id;
    if (oh[1])      id = ID_CPU_WR;
    else if (oh[2]) id = ID_CPU_RD;
    else            id = ID_UART;
    return id;
  endfunction

endpackage

// File: rtl/img_mem_arbiter_rr_arbiter3.sv
// Combinational 3-way round-robin arbiter: search starts one past last_grant.
module rr_arbiter3
  import img_mem_arbiter_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last_grant,
  output logic [2:0] grant
);

  logic [1:0] idx;

  always_comb begin
    grant = '0;
    idx   = '0;
    for (int unsigned k = 1; k <= 3; k++) begin
      idx = 2'((32'(last_grant) + k) % 3);
      if (grant == '0 && req[idx]) grant[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/img_mem_arbiter.sv
// Arbitrates UART and CPU read/write ports onto one shared image memory,
// one transaction at a time, with round-robin fairness and an ack timeout.
module img_mem_arbiter
  import img_mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_re,
  input  logic [ADDR_WIDTH-1:0] cpu_raddr,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_rd_ready,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_waddr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_wr_ready,
  input  logic                  uart_req,
  input  logic                  uart_we,
  input  logic [ADDR_WIDTH-1:0] uart_addr,
  input  logic [DATA_WIDTH-1:0] uart_wdata,
  output logic [DATA_WIDTH-1:0] uart_rdata,
  output logic                  uart_ack,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic                  busy,
  output logic                  timeout_err
);

  state_t                  state, state_nxt;
  req_id_t                 last_grant, owner, gid;
  logic [TO_CNT_WIDTH-1:0] to_cnt;
  logic [2:0]              req_vec, grant;
  logic                    acked, timed_out, resp;

  assign req_vec = {cpu_re, cpu_we, uart_req};

  rr_arbiter3 u_rr (
    .req        (req_vec),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign gid = onehot_to_id(grant);

  // An ack in ISSUE is honoured exactly like one in WAIT; elsewhere it is ignored.
  assign acked     = mem_ack && (state == ST_ISSUE || state == ST_WAIT);
  assign timed_out = (state == ST_WAIT) && !mem_ack &&
                     (to_cnt == TO_CNT_WIDTH'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (|req_vec) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = acked ? ST_RESP : ST_WAIT;
      ST_WAIT:  if (acked || timed_out) state_nxt = ST_RESP;
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      last_grant  <= ID_CPU_RD;
      owner       <= ID_UART;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      to_cnt      <= '0;
      timeout_err <= 1'b0;
      cpu_rdata   <= '0;
      uart_rdata  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (|req_vec) begin
            owner      <= gid;
            last_grant <= gid;
            case (gid)
              ID_UART: begin
                mem_we    <= uart_we;
                mem_addr  <= uart_addr;
                mem_wdata <= uart_wdata;
              end
              ID_CPU_WR: begin
                mem_we    <= 1'b1;
                mem_addr  <= cpu_waddr;
                mem_wdata <= cpu_wdata;
              end
              default: begin
                mem_we    <= 1'b0;
                mem_addr  <= cpu_raddr;
                mem_wdata <= '0;
              end
            endcase
          end
        end
        ST_ISSUE: to_cnt <= '0;
        ST_WAIT:  if (!mem_ack) to_cnt <= to_cnt + 1'b1;
        default:  ;
      endcase

      if (acked && !mem_we) begin
        if (owner == ID_UART) uart_rdata <= mem_rdata;
        else                  cpu_rdata  <= mem_rdata;
      end

      // A timed-out read still completes, returning zero data.
      if (timed_out) begin
        timeout_err <= 1'b1;
        if (!mem_we) begin
          if (owner == ID_UART) uart_rdata <= '0;
          else                  cpu_rdata  <= '0;
        end
      end
    end
  end

  assign mem_req      = (state == ST_ISSUE) || (state == ST_WAIT);
  assign busy         = (state != ST_IDLE);
  assign resp         = (state == ST_RESP);
  assign uart_ack     = resp && (owner == ID_UART);
  assign cpu_wr_ready = resp && (owner == ID_CPU_WR);
  assign cpu_rd_ready = resp && (owner == ID_CPU_RD);

endmodule
